// File: rtl/aes_xts_out_reorder_buf_if.sv
// Bus bundle for aes_xts_out_reorder_buf: write side from the XTS cipher core,
// FWFT stream side to the downstream sink, plus the sticky protocol-error status.
// Ports: inWr/inData/inBlockBeforeLast/inLast/inLastBlockBytes -> outWrReady,
//        outValid/outData/outKeep/outLast <- inReady, outProtoErr.
// slave modport = the reorder buffer; master modport = core + sink side.
interface aes_xts_out_reorder_buf_if #(
  parameter int DATA_W = 128,
  parameter int SZ_W   = $clog2(DATA_W/8)
);
  // write side
  logic                inWr;
  logic [DATA_W-1:0]   inData;
  logic                inBlockBeforeLast;
  logic                inLast;
  logic [SZ_W-1:0]     inLastBlockBytes;
  logic                outWrReady;
  // output side
  logic                outValid;
  logic                inReady;
  logic [DATA_W-1:0]   outData;
  logic [DATA_W/8-1:0] outKeep;
  logic                outLast;
  // status
  logic                outProtoErr;

  modport slave (
    input  inWr, inData, inBlockBeforeLast, inLast, inLastBlockBytes, inReady,
    output outWrReady, outValid, outData, outKeep, outLast, outProtoErr
  );

  modport master (
    output inWr, inData, inBlockBeforeLast, inLast, inLastBlockBytes, inReady,
    input  outWrReady, outValid, outData, outKeep, outLast, outProtoErr
  );
endinterface

// File: rtl/aes_xts_out_reorder_buf.sv
// Purpose: AES-XTS output stage; ciphertext-stealing reorder (hold CC, emit C(n-1),
//          then the truncated final block with a byte-keep mask) into a FWFT FIFO.
// Latency: 1 cycle push-to-head; the masked final block follows C(n-1) one edge later.
// Backpressure: outWrReady drops when the FIFO is full or while flushing the stolen
//          block; writes offered while it is low are dropped.
// Ports: inClk, inRstN (async active-low); bus (slave modport of
//        aes_xts_out_reorder_buf_if) carrying the write, stream and status signals.
// Optional: define AES_XTS_OUT_PROTO_CHECK_EN to enable the sticky outProtoErr flag.
module aes_xts_out_reorder_buf #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int SZ_W       = $clog2(DATA_W/8)
) (
  input  logic                     inClk,
  input  logic                     inRstN,
  aes_xts_out_reorder_buf_if.slave bus
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_pend;
  logic [SZ_W-1:0]    r_size;

  logic [DATA_W-1:0]  r_mem_dat  [FIFO_DEPTH];
  logic [KEEP_W-1:0]  r_mem_keep [FIFO_DEPTH];
  logic               r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_room;
  logic               w_wr_rdy;
  logic               w_acc;
  logic               w_vld;
  logic               w_pop;
  logic               w_push;
  logic [DATA_W-1:0]  w_push_dat;
  logic [KEEP_W-1:0]  w_push_keep;
  logic               w_push_last;
  logic [KEEP_W-1:0]  w_kmask;
  logic [DATA_W-1:0]  w_dmask;

  // Ready depends only on registered count/state, so a same-cycle pop on a
  // full FIFO never opens a write slot.
  assign w_room   = (r_count < DEPTH_C);
  assign w_wr_rdy = w_room && (r_state != ST_FLUSH);
  assign w_acc    = bus.inWr && w_wr_rdy;
  assign w_vld    = (r_count != '0);
  assign w_pop    = w_vld && bus.inReady;

  // Keep mask has the low r_size bits set; the data mask widens each keep bit to a byte.
  always_comb begin
    w_kmask = '0;
    w_dmask = '0;
    for (int b = 0; b < KEEP_W; b++) begin
      w_kmask[b]        = (SZ_W'(b) < r_size);
      w_dmask[8*b +: 8] = {8{w_kmask[b]}};
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_dat  = '0;
    w_push_keep = '0;
    w_push_last = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && !bus.inBlockBeforeLast) begin
          w_push      = 1'b1;
          w_push_dat  = bus.inData;
          w_push_keep = '1;
          w_push_last = bus.inLast;
        end
      end
      ST_HOLD: begin
        // C(n-1): flags on this write carry no data meaning
        if (w_acc) begin
          w_push      = 1'b1;
          w_push_dat  = bus.inData;
          w_push_keep = '1;
          w_push_last = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (w_room) begin
          w_push      = 1'b1;
          w_push_dat  = r_pend & w_dmask;
          w_push_keep = w_kmask;
          w_push_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stealing FSM; pending/size survive until the next IDLE capture.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_size  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc && bus.inBlockBeforeLast) begin
            r_pend  <= bus.inData;
            r_size  <= bus.inLastBlockBytes;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_acc) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (w_room) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIFO control; push only happens with room, pop only with data.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: the head is gated to zero whenever the FIFO is empty.
  always_ff @(posedge inClk) begin
    if (w_push) begin
      r_mem_dat[r_wr_ptr]  <= w_push_dat;
      r_mem_keep[r_wr_ptr] <= w_push_keep;
      r_mem_last[r_wr_ptr] <= w_push_last;
    end
  end

  assign bus.outWrReady = w_wr_rdy;
  assign bus.outValid   = w_vld;
  assign bus.outData    = w_vld ? r_mem_dat[r_rd_ptr]  : '0;
  assign bus.outKeep    = w_vld ? r_mem_keep[r_rd_ptr] : '0;
  assign bus.outLast    = w_vld ? r_mem_last[r_rd_ptr] : 1'b0;

`ifdef AES_XTS_OUT_PROTO_CHECK_EN
  logic r_proto_err;
  logic w_err;

  assign w_err = (bus.inWr && !w_wr_rdy)
              || ((r_state == ST_HOLD) && w_acc && (bus.inBlockBeforeLast || bus.inLast))
              || ((r_state == ST_IDLE) && w_acc && bus.inBlockBeforeLast
                  && (bus.inLastBlockBytes == '0));

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN)    r_proto_err <= 1'b0;
    else if (w_err) r_proto_err <= 1'b1;
  end

  assign bus.outProtoErr = r_proto_err;
`else
  assign bus.outProtoErr = 1'b0;
`endif

endmodule
